axi_burst_sequencer: RTL
========================

// Module: axi_burst_sequencer
// PURPOSE
//  Expands one AXI4 burst request (addr/len/size/burst/id) into a stream of per-beat
//  addresses, byte-lane strobes and LAST flags. Supports FIXED, INCR and WRAP bursts,
//  narrow and unaligned transfers, and AXI4 lengths of 1..256 beats.
//  Sits behind AR/AW skid buffers in slaves and bridges. Drives RAM indexing and WSTRB checking.
// PARAMETERS
//  C_AXI_ADDR_WIDTH  32  address width, >= 12
//  C_AXI_DATA_WIDTH  32  bus width in bits, power of 2, 8..1024
//  C_AXI_ID_WIDTH     4  transaction ID width, passed through unchanged
//  OPT_LOWPOWER       0  1: zero o_addr/o_strb/o_id whenever o_valid is low
// PORTS
//  S_AXI_ACLK     in   1        clock
//  S_AXI_ARESETN  in   1        reset: asynchronous assert, active-low
//  i_valid        in   1        request valid
//  o_ready        out  1        request accepted when i_valid && o_ready
//  i_addr         in   AW       start address; may be unaligned for FIXED/INCR
//  i_len          in   8        beats-1
//  i_size         in   3        log2(bytes per beat)
//  i_burst        in   2        00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  i_id           in   IW       request ID
//  o_valid        out  1        beat valid
//  i_ready        in   1        beat consumed when o_valid && i_ready
//  o_addr         out  AW       beat byte address
//  o_strb         out  DW/8     active byte lanes of this beat
//  o_last         out  1        final beat of the burst
//  o_id           out  IW       ID of the current burst
//  o_err          out  1        request illegal; constant across all beats of that burst
// BEHAVIOUR
//  - Reset (async, ARESETN low): o_valid=0, o_last=0, o_err=0, o_ready=0, beat counter=0,
//    state IDLE. o_ready rises on the first clock edge after deassertion.
//  - States: IDLE (o_ready=1), BURST (o_valid=1).
//  - o_ready = !o_valid || (i_ready && o_last). Back-to-back bursts have zero bubble.
//  - Accept in cycle N -> first beat valid in cycle N+1. All beat outputs are registered.
//  - Beat outputs hold stable while o_valid && !i_ready.
//  - Beat counter: 8-bit down-counter loaded with i_len. o_last = (count==0).
//    Leave BURST on the last handshake unless a new request is accepted in the same cycle.
//  - Next address, with DSZ=log2(DW/8) and S=1<<size:
//    FIXED: address held.
//    INCR: (addr & ~(S-1)) + S. Bits [AW-1:12] held, so the address wraps within the 4KB page.
//    WRAP: window = (len+1)*S, base aligned to the window. Low bits wrap inside the window.
//  - Strobe: lanes from addr[DSZ-1:0] up to the end of the S-aligned container. All other lanes 0.
//  - o_err set at acceptance for any of:
//    burst==11; size>DSZ; WRAP with len not in {1,3,7,15}; WRAP with unaligned addr;
//    INCR whose aligned start + (len+1)*S crosses a 4KB page.
//    Reserved burst is sequenced as INCR. Oversize is clamped to DSZ.
//    Erroneous bursts still produce all len+1 beats.
//  - Arithmetic is in AW bits. No carry propagates above bit 11 for INCR/WRAP.
// STRUCTURE
//  - Shared package/include: burst encodings (BURST_FIXED/INCR/WRAP/RSVD), 4KB page constant,
//    DSZ function.
//  - One combinational sub-module, axi_beat_addr: (addr, size, burst, len) -> (next_addr, strb).
//    Formally mitered against the next-address model.
// TESTING (DW=32)
//  1. INCR 0x1002 size1 len3 -> addresses 0x1002/04/06/08; strobes 1100,0011,1100,0011; last on beat 4.
//  2. INCR 0x1001 size2 len1 -> 0x1001 strobe 1110, then 0x1004 strobe 1111. o_err=0.
//  3. WRAP 0x2038 size2 len3 -> 0x2038, 0x203C, 0x2030, 0x2034. WRAP len2 -> o_err=1, 3 beats.
//  4. INCR 0x0FFC size2 len1 -> o_err=1; beats 0x0FFC, then 0x0000 (page bits held).
//  5. Two len0 requests with i_ready=1 -> o_valid high 2 consecutive cycles; o_ready never drops.
//     i_ready low 3 cycles mid-burst -> outputs stable.
//  6. ARESETN low during beat 2 of len7 -> o_valid=0 immediately.
//     After release, a FIXED 0x40 len1 request gives 2 beats at 0x40 with no residue from the old burst.

Source files
------------

// File: rtl/axi_burst_sequencer_pkg.sv
// axi_burst_sequencer_pkg: burst encodings, 4KB page size, FSM states and bus-size helper
package axi_burst_sequencer_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam int PAGE_BYTES = 4096;
  typedef enum logic {IDLE, BURST} state_e;
  function automatic int dsz(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/axi_beat_addr.sv
// axi_beat_addr: next beat address and byte-lane strobe for the current beat
// ports: addr/size/burst/len describe the current beat -> next_addr, strb (lanes of addr)
module axi_beat_addr
  import axi_burst_sequencer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0]   addr,
  input  logic [2:0]      size,
  input  logic [1:0]      burst,
  input  logic [7:0]      len,
  output logic [AW-1:0]   next_addr,
  output logic [DW/8-1:0] strb
);
  localparam int NB = DW / 8;
  logic [11:0] s, aligned, incr, wmask;
  int lo, hi;
  // Only the low 12 bits move, so INCR and WRAP never carry out of the 4KB page.
  always_comb begin
    s = 12'd1 << size;
    aligned = addr[11:0] & ~(s - 12'd1);
    incr = aligned + s;
    wmask = ((12'(len) + 12'd1) << size) - 12'd1;
    next_addr = {addr[AW-1:12], burst == BURST_FIXED ? addr[11:0] :
                 burst == BURST_WRAP ? (addr[11:0] & ~wmask) | (incr & wmask) : incr};
    lo = int'(addr[11:0]) & (NB - 1);
    hi = (lo & ~(int'(s) - 1)) + int'(s) - 1;
    for (int i = 0; i < NB; i++) strb[i] = i >= lo && i <= hi;
  end
endmodule

// File: rtl/axi_burst_sequencer.sv
// axi_burst_sequencer: expands one AXI4 burst request into per-beat address/strobe/last
// ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset;
//        i_valid/o_ready + i_addr/i_len/i_size/i_burst/i_id request;
//        o_valid/i_ready + o_addr/o_strb/o_last/o_id/o_err beat stream
module axi_burst_sequencer
  import axi_burst_sequencer_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter bit OPT_LOWPOWER     = 1'b0
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [7:0]                    i_len,
  input  logic [2:0]                    i_size,
  input  logic [1:0]                    i_burst,
  input  logic [C_AXI_ID_WIDTH-1:0]     i_id,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_addr,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_strb,
  output logic                          o_last,
  output logic [C_AXI_ID_WIDTH-1:0]     o_id,
  output logic                          o_err
);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int NB = C_AXI_DATA_WIDTH / 8;
  localparam int DSZ = dsz(C_AXI_DATA_WIDTH);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, next_addr;
  logic [7:0] count_q, count_d, len_q, len_d;
  logic [2:0] size_q, size_d, sz;
  logic [1:0] burst_q, burst_d, beff;
  logic [C_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic err_q, err_d, rdy_q, err, len_ok, unal, accept, advance;
  logic [11:0] smask;
  logic [NB-1:0] strb;
  int span;
  axi_beat_addr #(.AW(AW), .DW(C_AXI_DATA_WIDTH)) u_beat (
    .addr(addr_q), .size(size_q), .burst(burst_q), .len(len_q), .next_addr(next_addr), .strb(strb)
  );
  // rdy_q keeps o_ready low until the first clock edge after reset release.
  assign o_valid = state_q == BURST;
  assign o_last  = o_valid && count_q == 8'd0;
  assign o_ready = rdy_q && (!o_valid || (i_ready && o_last));
  assign o_err   = err_q;
  assign o_addr  = (OPT_LOWPOWER && !o_valid) ? '0 : addr_q;
  assign o_strb  = (OPT_LOWPOWER && !o_valid) ? '0 : strb;
  assign o_id    = (OPT_LOWPOWER && !o_valid) ? '0 : id_q;
  // Reserved bursts and WRAP with an illegal length are sequenced as INCR; oversize clamps to the bus.
  always_comb begin
    sz = i_size > 3'(DSZ) ? 3'(DSZ) : i_size;
    smask = (12'd1 << sz) - 12'd1;
    len_ok = i_len inside {8'd1, 8'd3, 8'd7, 8'd15};
    unal = |(i_addr[11:0] & smask);
    span = int'(i_addr[11:0] & ~smask) + ((int'(i_len) + 1) << sz);
    beff = (i_burst == BURST_RSVD || (i_burst == BURST_WRAP && !len_ok)) ? BURST_INCR : i_burst;
    err = i_burst == BURST_RSVD || i_size > 3'(DSZ) || (i_burst == BURST_WRAP && (!len_ok || unal)) ||
          (i_burst == BURST_INCR && span > PAGE_BYTES);
    accept = i_valid && o_ready;
    advance = o_valid && i_ready;
    state_d = state_q;
    addr_d = addr_q;
    count_d = count_q;
    len_d = len_q;
    size_d = size_q;
    burst_d = burst_q;
    id_d = id_q;
    err_d = err_q;
    if (accept) begin
      state_d = BURST;
      addr_d = i_addr;
      count_d = i_len;
      len_d = i_len;
      size_d = sz;
      burst_d = beff;
      id_d = i_id;
      err_d = err;
    end else if (advance) begin
      state_d = o_last ? IDLE : BURST;
      addr_d = o_last ? addr_q : next_addr;
      count_d = o_last ? count_q : count_q - 8'd1;
    end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      addr_q <= '0;
      count_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      id_q <= '0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      count_q <= count_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      id_q <= id_d;
      err_q <= err_d;
      rdy_q <= 1'b1;
    end
  end
endmodule
